// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch requester, load/store requester and the shared memory port.
// slave = arbiter side, master = requesters and memory side.
interface mem_arbiter_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport slave (
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_rmask, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch vs load/store) onto one memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed dmem priority.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IMEM_BUSY = 2'd1,
    DMEM_BUSY = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  rmask_r;
  logic [3:0]  wmask_r;
  logic        imem_req_s;
  logic        dmem_req_s;
  logic        grant_imem_s;
  logic        grant_dmem_s;

`ifdef ARB_ROUND_ROBIN_EN
  // 1'b0 = imem granted last, 1'b1 = dmem granted last
  logic        last_grant_r;
`endif

  // Request detection and winner selection
  always_comb begin
    imem_req_s = (bus.imem_rmask != 4'd0);
    dmem_req_s = ((bus.dmem_rmask | bus.dmem_wmask) != 4'd0);
`ifdef ARB_ROUND_ROBIN_EN
    grant_dmem_s = dmem_req_s && (!imem_req_s || (last_grant_r == 1'b0));
`else
    grant_dmem_s = dmem_req_s;
`endif
    grant_imem_s = imem_req_s && !grant_dmem_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_dmem_s) begin
          state_s = DMEM_BUSY;
        end else if (grant_imem_s) begin
          state_s = IMEM_BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      IMEM_BUSY, DMEM_BUSY: begin
        if (bus.mem_resp) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and request latch; only IDLE captures a new request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rmask_r <= 4'd0;
      wmask_r <= 4'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && grant_dmem_s) begin
        addr_r  <= bus.dmem_addr;
        wdata_r <= bus.dmem_wdata;
        rmask_r <= bus.dmem_rmask;
        wmask_r <= bus.dmem_wmask;
      end else if ((state_r == IDLE) && grant_imem_s) begin
        addr_r  <= bus.imem_addr;
        wdata_r <= 32'd0;
        rmask_r <= bus.imem_rmask;
        wmask_r <= 4'd0;
      end else begin
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
        rmask_r <= rmask_r;
        wmask_r <= wmask_r;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who won the most recent grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b0;
    end else if ((state_r == IDLE) && grant_dmem_s) begin
      last_grant_r <= 1'b1;
    end else if ((state_r == IDLE) && grant_imem_s) begin
      last_grant_r <= 1'b0;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Memory port driven from the latch while busy; response routed to the granted side only
  always_comb begin
    bus.mem_addr   = 32'd0;
    bus.mem_rmask  = 4'd0;
    bus.mem_wmask  = 4'd0;
    bus.mem_wdata  = 32'd0;
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = 32'd0;
    case (state_r)
      IMEM_BUSY: begin
        bus.mem_addr  = addr_r;
        bus.mem_rmask = rmask_r;
        bus.mem_wmask = wmask_r;
        bus.mem_wdata = wdata_r;
        if (bus.mem_resp) begin
          bus.imem_resp  = 1'b1;
          bus.imem_rdata = bus.mem_rdata;
        end else begin
          bus.imem_resp  = 1'b0;
          bus.imem_rdata = 32'd0;
        end
      end
      DMEM_BUSY: begin
        bus.mem_addr  = addr_r;
        bus.mem_rmask = rmask_r;
        bus.mem_wmask = wmask_r;
        bus.mem_wdata = wdata_r;
        if (bus.mem_resp) begin
          bus.dmem_resp  = 1'b1;
          bus.dmem_rdata = bus.mem_rdata;
        end else begin
          bus.dmem_resp  = 1'b0;
          bus.dmem_rdata = 32'd0;
        end
      end
      default: begin
        bus.mem_addr = 32'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: expected transactions are queued when requests are
// driven and compared when they appear on the memory port and come back as responses.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic is_d, input logic [31:0] addr, input logic [3:0] rmask,
                      input logic [3:0] wmask, input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    t.is_d  = is_d;
    t.addr  = addr;
    t.rmask = rmask;
    t.wmask = wmask;
    t.wdata = wdata;
    t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  task automatic clear_inputs();
    bus.imem_addr  = 32'd0;
    bus.imem_rmask = 4'd0;
    bus.dmem_addr  = 32'd0;
    bus.dmem_rmask = 4'd0;
    bus.dmem_wmask = 4'd0;
    bus.dmem_wdata = 32'd0;
    bus.mem_rdata  = 32'd0;
    bus.mem_resp   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_rmask"}, {28'd0, bus.mem_rmask}, 32'd0);
    check({tag, "_mem_wmask"}, {28'd0, bus.mem_wmask}, 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_imem_resp"}, {31'd0, bus.imem_resp}, 32'd0);
    check({tag, "_dmem_resp"}, {31'd0, bus.dmem_resp}, 32'd0);
  endtask

  // Memory model: wait for the next grant, compare it to the scoreboard head, answer after lat cycles.
  task automatic serve(input int lat, input bit chg, input logic [31:0] new_iaddr);
    txn_t t;
    bit   got;
    int   n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.mem_rmask != 4'd0 || bus.mem_wmask != 4'd0) got = 1'b1;
    end
    check("grant_seen", {31'd0, got}, 32'd1);
    if (!got) return;
    check("sb_has_entry", {31'd0, (exp_q.size() != 0)}, 32'd1);
    if (exp_q.size() == 0) return;
    t = exp_q.pop_front();
    bus.mem_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < lat; c++) begin
      if (c > 0) @(negedge clk);
      check("mem_addr", bus.mem_addr, t.addr);
      check("mem_rmask", {28'd0, bus.mem_rmask}, {28'd0, t.rmask});
      check("mem_wmask", {28'd0, bus.mem_wmask}, {28'd0, t.wmask});
      check("mem_wdata", bus.mem_wdata, t.wdata);
      if (c == lat - 1) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = t.rdata;
        #1;
        check("imem_resp", {31'd0, bus.imem_resp}, {31'd0, !t.is_d});
        check("dmem_resp", {31'd0, bus.dmem_resp}, {31'd0, t.is_d});
        check("imem_rdata", bus.imem_rdata, t.is_d ? 32'd0 : t.rdata);
        check("dmem_rdata", bus.dmem_rdata, t.is_d ? t.rdata : 32'd0);
      end else begin
        #1;
        check("early_resp", {30'd0, bus.imem_resp, bus.dmem_resp}, 32'd0);
        if (chg && c == 0) bus.imem_addr = new_iaddr;
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'd0;
    check("post_resp_masks", {28'd0, bus.mem_rmask | bus.mem_wmask}, 32'd0);
    check("post_resp_pulse", {30'd0, bus.imem_resp, bus.dmem_resp}, 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Fetch only, memory answers after 3 cycles
    bus.imem_addr  = 32'h6000_0000;
    bus.imem_rmask = 4'hF;
    push(1'b0, 32'h6000_0000, 4'hF, 4'h0, 32'd0, 32'h0000_0013);
    serve(3, 1'b0, 32'd0);
    clear_inputs();

    // Partial store
    bus.dmem_addr  = 32'h6000_1000;
    bus.dmem_wmask = 4'h3;
    bus.dmem_wdata = 32'hDEAD_BEEF;
    push(1'b1, 32'h6000_1000, 4'h0, 4'h3, 32'hDEAD_BEEF, 32'h0000_0000);
    serve(2, 1'b0, 32'd0);
    clear_inputs();

    // Read and write masks together pass through untouched
    bus.dmem_addr  = 32'h6000_1004;
    bus.dmem_rmask = 4'hC;
    bus.dmem_wmask = 4'h3;
    bus.dmem_wdata = 32'h0123_4567;
    push(1'b1, 32'h6000_1004, 4'hC, 4'h3, 32'h0123_4567, 32'hCAFE_F00D);
    serve(1, 1'b0, 32'd0);
    clear_inputs();

    // Granted fetch changes its address mid-transaction
    bus.imem_addr  = 32'h6000_0004;
    bus.imem_rmask = 4'hF;
    push(1'b0, 32'h6000_0004, 4'hF, 4'h0, 32'd0, 32'h0000_0093);
    serve(3, 1'b1, 32'h6000_0008);
    clear_inputs();

    // Spurious memory response while idle
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    #1;
    check("spur_imem_resp", {31'd0, bus.imem_resp}, 32'd0);
    check("spur_dmem_resp", {31'd0, bus.dmem_resp}, 32'd0);
    check("spur_dmem_rdata", bus.dmem_rdata, 32'd0);
    @(negedge clk);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'd0;
    check_quiet("spur_after");

    // Both requesting every cycle, starting right after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.imem_addr  = 32'h6000_0100;
    bus.imem_rmask = 4'hF;
    bus.dmem_addr  = 32'h6000_2000;
    bus.dmem_rmask = 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
    push(1'b1, 32'h6000_2000, 4'hF, 4'h0, 32'd0, 32'hD000_0001);
    push(1'b0, 32'h6000_0100, 4'hF, 4'h0, 32'd0, 32'hA000_0001);
    push(1'b1, 32'h6000_2000, 4'hF, 4'h0, 32'd0, 32'hD000_0002);
    push(1'b0, 32'h6000_0100, 4'hF, 4'h0, 32'd0, 32'hA000_0002);
`else
    push(1'b1, 32'h6000_2000, 4'hF, 4'h0, 32'd0, 32'hD000_0001);
    push(1'b1, 32'h6000_2000, 4'hF, 4'h0, 32'd0, 32'hD000_0002);
    push(1'b1, 32'h6000_2000, 4'hF, 4'h0, 32'd0, 32'hD000_0003);
    push(1'b1, 32'h6000_2000, 4'hF, 4'h0, 32'd0, 32'hD000_0004);
`endif
    for (int k = 0; k < 4; k++) serve(1, 1'b0, 32'd0);
    bus.dmem_rmask = 4'h0;
    push(1'b0, 32'h6000_0100, 4'hF, 4'h0, 32'd0, 32'hA000_00FF);
    serve(1, 1'b0, 32'd0);
    clear_inputs();

    // Reset in the middle of a load, then a stale response
    bus.dmem_addr  = 32'h6000_3000;
    bus.dmem_rmask = 4'hF;
    @(negedge clk);
    check("busy_before_rst", {28'd0, bus.mem_rmask}, 32'h0000_000F);
    rst = 1'b1;
    bus.dmem_rmask = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    #1;
    check("stale_dmem_resp", {31'd0, bus.dmem_resp}, 32'd0);
    check("stale_dmem_rdata", bus.dmem_rdata, 32'd0);
    check_quiet("stale");
    @(negedge clk);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'd0;
    check_quiet("stale_after");

    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
